fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL provide: clk  input  1  core clock; all state updates on rising edge.
REQ-002 SHALL provide: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL provide: mem_rd  output  1  read request, held until acknowledged.
REQ-004 SHALL provide: mem_addr  output  16  read address, equal to the current PC while mem_rd=1.
REQ-005 SHALL provide: mem_ack  input  1  read data valid this cycle; ignored when mem_rd=0.
REQ-006 SHALL provide: mem_rdata  input  8  read byte, sampled when mem_rd and mem_ack are both 1.
REQ-007 SHALL provide: instr  output  instr_t  presented opcode byte, to decode.
REQ-008 SHALL provide: o_valid  output  1  instr is valid.
REQ-009 SHALL provide: i_ready  input  1  consumer accepts instr; a transfer occurs when o_valid and i_ready are both 1.
REQ-010 SHALL provide: o_is_instr16  output  1  instr is the body byte following an 0xCB prefix; feeds decode i_is_instr16.
REQ-011 SHALL provide: o_pc  output  16  address instr was fetched from.
REQ-012 SHALL provide: redirect  input  1  load a new PC (jump/call/ret/rst/irq).
REQ-013 SHALL provide: redirect_pc  input  16  target PC for redirect.
REQ-014 SHALL provide: halt  input  1  stop fetching after the current transfer (HALT/STOP).

Function
REQ-015 SHALL implement FSM states S_FETCH, S_HOLD and S_HALTED.
REQ-016 S_FETCH SHALL drive mem_rd=1 and mem_addr=pc; on mem_ack, capture mem_rdata into instr, set o_pc=pc and pc<=pc+1, then enter S_HOLD.
REQ-017 S_HOLD SHALL drive o_valid=1 with instr stable; without a transfer, remain in S_HOLD.
REQ-018 On a transfer in S_HOLD, enter S_HALTED if halt=1, otherwise S_FETCH.
REQ-019 Latency SHALL be one cycle: mem_ack in cycle N gives o_valid=1 in cycle N+1.
REQ-020 PC increment SHALL wrap 16 bits: 0xFFFF+1 = 0x0000.
REQ-021 On a transfer of 0xCB with o_is_instr16=0, the prefix flag SHALL be set so the next presented byte has o_is_instr16=1.
REQ-022 On a transfer with o_is_instr16=1, the prefix flag SHALL clear; 0xCB as a body byte SHALL NOT re-set it.
REQ-023 redirect SHALL have highest priority in any state: pc<=redirect_pc, o_valid<=0, prefix flag cleared, next state S_FETCH.
REQ-024 An mem_ack arriving in the same cycle as redirect SHALL be discarded.
REQ-025 S_HALTED SHALL drive mem_rd=0 and o_valid=0; leave to S_FETCH on redirect, or when halt deasserts.
REQ-026 mem_addr SHALL NOT change while mem_rd=1 and mem_ack=0, except on redirect.

Reset
REQ-027 On rst, the block SHALL set pc=RESET_PC (0x0000), state=S_FETCH, o_valid=0, o_is_instr16=0, instr=0x00, o_pc=0x0000, mem_rd=0 in the reset cycle.
REQ-028 rst mid-fetch SHALL abandon the outstanding request; any mem_ack in the reset cycle SHALL be ignored.

Configuration
REQ-029 With FETCH_PREFETCH_EN defined, a one-entry prefetch buffer SHALL fetch pc while in S_HOLD, and a transfer SHALL move the buffered byte to instr with no bubble (o_valid stays 1).
REQ-030 With FETCH_PREFETCH_EN defined, redirect and halt SHALL flush the buffer.
REQ-031 Without FETCH_PREFETCH_EN, the block SHALL perform no request during S_HOLD, giving at least one invalid cycle between transfers.

Structure
REQ-032 fetch_state_t and the RESET_PC constant SHALL live in sm83_pkg; the 0xCB opcode SHALL use the existing OP_INSTR_16.
REQ-033 The prefetch buffer SHALL be sub-module fetch_pbuf, instantiated only under FETCH_PREFETCH_EN; no other sub-modules.

Verification
REQ-034 Reset, then memory 0x0000=0x3E, 0x0001=0x42, zero-wait ack, i_ready=1 -> instr 0x3E at o_pc 0x0000, then 0x42 at o_pc 0x0001; o_is_instr16=0.
REQ-035 Bytes 0xCB,0xCB,0x00 -> o_is_instr16 values 0,1,0.
REQ-036 i_ready=0 for 5 cycles with instr=0x06 -> instr, o_pc and o_valid stable; mem_rd=0 (without macro).
REQ-037 redirect to 0x1234 while awaiting ack, with ack in the same cycle -> byte dropped; next mem_addr=0x1234; prefix cleared.
REQ-038 pc=0xFFFF fetch -> next mem_addr=0x0000.
REQ-039 Transfer with halt=1 -> mem_rd=0 and o_valid=0 until halt falls; then fetch resumes at the next PC. With macro: back-to-back transfers with no o_valid gap.

Source files
------------

// File: rtl/sm83_pkg.sv
// Shared types and constants for the SM83 front end.
// Holds the fetch FSM state type, reset PC and prefix opcode.
package sm83_pkg;

   typedef logic [7:0] instr_t;

   typedef enum logic [1:0] {
      S_FETCH,
      S_HOLD,
      S_HALTED
   } fetch_state_t;

   localparam logic [15:0] RESET_PC    = 16'h0000;
   localparam instr_t      OP_INSTR_16 = 8'hCB;

   function automatic logic [15:0] pc_inc(input logic [15:0] pc);
      return pc + 16'd1;
   endfunction

endpackage

// File: rtl/fetch_pbuf.sv
// One-entry prefetch buffer for the fetch stage.
// Instantiated only when FETCH_PREFETCH_EN is defined.
module fetch_pbuf
   import sm83_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   flush,
   input  logic   load,
   input  logic   take,
   input  instr_t wdata,
   output logic   valid,
   output instr_t rdata
);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
      end else if (take) begin
         valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         rdata <= wdata;
      end
   end

endmodule

// File: rtl/fetch.sv
// Byte fetch stage: single-byte reads, 0xCB prefix tracking.
// Define FETCH_PREFETCH_EN to add a one-entry prefetch buffer.
module fetch
   import sm83_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output instr_t      instr,
   output logic        o_valid,
   input  logic        i_ready,
   output logic        o_is_instr16,
   output logic [15:0] o_pc,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   input  logic        halt
);

   fetch_state_t state, next_state;
   logic [15:0]  pc;
   logic         cap, pop, load, rewind;
   logic         pb_valid;
   instr_t       pb_data;
   logic         xfer;

   assign xfer     = o_valid & i_ready;
   assign mem_addr = pc;

`ifdef FETCH_PREFETCH_EN
   fetch_pbuf u_pbuf (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect | rewind),
      .load  (load),
      .take  (pop),
      .wdata (mem_rdata),
      .valid (pb_valid),
      .rdata (pb_data)
   );
`else
   assign pb_valid = 1'b0;
   assign pb_data  = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      mem_rd     = 1'b0;
      o_valid    = 1'b0;
      cap        = 1'b0;
      pop        = 1'b0;
      load       = 1'b0;
      rewind     = 1'b0;
      unique case (state)
         S_FETCH: begin
            mem_rd = 1'b1;
            if (mem_ack) begin
               cap        = 1'b1;
               next_state = S_HOLD;
            end
         end
         S_HOLD: begin
            o_valid = 1'b1;
`ifdef FETCH_PREFETCH_EN
            mem_rd = ~pb_valid;
`endif
            if (i_ready) begin
               if (halt) begin
                  next_state = S_HALTED;
                  rewind     = 1'b1;
               end else if (pb_valid) begin
                  pop = 1'b1;
               end else if (mem_rd && mem_ack) begin
                  cap = 1'b1;
               end else begin
                  next_state = S_FETCH;
               end
            end else if (mem_rd && mem_ack) begin
               load = 1'b1;
            end
         end
         S_HALTED: begin
            if (!halt) begin
               next_state = S_FETCH;
            end
         end
         default: next_state = S_FETCH;
      endcase
      // Redirect and reset discard any ack landing this cycle
      if (rst || redirect) begin
         next_state = S_FETCH;
         cap        = 1'b0;
         pop        = 1'b0;
         load       = 1'b0;
         rewind     = 1'b0;
      end
      if (rst) begin
         mem_rd  = 1'b0;
         o_valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc           <= RESET_PC;
         instr        <= '0;
         o_pc         <= '0;
         o_is_instr16 <= 1'b0;
      end else if (redirect) begin
         pc           <= redirect_pc;
         o_is_instr16 <= 1'b0;
      end else begin
         // A body byte never re-arms the prefix, even if it is 0xCB
         if (xfer) begin
            o_is_instr16 <= ~o_is_instr16 & (instr == OP_INSTR_16);
         end
         if (cap) begin
            instr <= mem_rdata;
            o_pc  <= pc;
            pc    <= pc_inc(pc);
         end
         if (load) begin
            pc <= pc_inc(pc);
         end
         if (pop) begin
            instr <= pb_data;
            o_pc  <= pc_inc(o_pc);
         end
         // Halt drops any prefetched byte, so resume right after o_pc
         if (rewind) begin
            pc <= pc_inc(o_pc);
         end
      end
   end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed cases then random traffic
// checked against a byte-stream model of program memory.
module tb_fetch;
   import sm83_pkg::*;

   logic        clk;
   logic        rst;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   instr_t      instr;
   logic        o_valid;
   logic        i_ready;
   logic        o_is_instr16;
   logic [15:0] o_pc;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halt;

   fetch dut (
      .clk          (clk),
      .rst          (rst),
      .mem_rd       (mem_rd),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .instr        (instr),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_is_instr16 (o_is_instr16),
      .o_pc         (o_pc),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .halt         (halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  b;
      logic [15:0] pc;
      logic        p;
   } xfer_t;

   logic [7:0]  mem [65536];
   xfer_t       xlog [$];
   int          n_chk;
   int          n_pass;
   int          ack_mode;
   logic [15:0] exp_pc;
   logic        exp_pfx;
   logic        halted_exp;
   logic        wait_prev;
   logic [15:0] prev_addr;
   logic        prev_xf;
   int          b2b;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic settle();
      #1;
      case (ack_mode)
         0:       mem_ack = 1'b1;
         1:       mem_ack = 1'($urandom % 2);
         2:       mem_ack = 1'b0;
         default: mem_ack = 1'b1;
      endcase
      mem_rdata = mem_rd ? mem[mem_addr] : 8'($urandom);
      #1;
   endtask

   task automatic commit();
      logic xf;
      xf = o_valid && i_ready;
      if (rst) begin
         check("rst_mem_rd", mem_rd, 0);
         check("rst_valid", o_valid, 0);
         exp_pc     = 16'h0000;
         exp_pfx    = 1'b0;
         halted_exp = 1'b0;
         wait_prev  = 1'b0;
         prev_xf    = 1'b0;
      end else begin
         if (halted_exp) begin
            check("halted_rd", mem_rd, 0);
            check("halted_valid", o_valid, 0);
            if (!halt || redirect) halted_exp = 1'b0;
         end
         if (wait_prev && mem_rd) check("addr_hold", mem_addr, prev_addr);
`ifndef FETCH_PREFETCH_EN
         if (o_valid) check("hold_no_rd", mem_rd, 0);
         if (xf) check("xfer_gap", prev_xf, 0);
`endif
         if (xf && prev_xf) b2b++;
         if (xf) begin
            check("instr", instr, mem[exp_pc]);
            check("o_pc", o_pc, exp_pc);
            check("is16", o_is_instr16, exp_pfx);
            xlog.push_back('{b: instr, pc: o_pc, p: o_is_instr16});
            if (exp_pfx) exp_pfx = 1'b0;
            else if (mem[exp_pc] == 8'hCB) exp_pfx = 1'b1;
            exp_pc = exp_pc + 16'd1;
            if (halt && !redirect) halted_exp = 1'b1;
         end
         if (redirect) begin
            exp_pc  = redirect_pc;
            exp_pfx = 1'b0;
         end
         wait_prev = mem_rd && !mem_ack && !redirect;
         prev_addr = mem_addr;
         prev_xf   = xf;
      end
      @(negedge clk);
   endtask

   task automatic cycle();
      settle();
      commit();
   endtask

   task automatic wait_log(input int n, input int budget);
      int k = 0;
      while (xlog.size() < n && k < budget) begin
         cycle();
         k++;
      end
      check("wait_xfer", 32'(xlog.size() >= n), 1);
   endtask

   logic [7:0] eb [5];
   logic       ep [5];
   int         n0;
   int         nw;

   initial begin
      n_chk = 0; n_pass = 0; b2b = 0;
      exp_pc = '0; exp_pfx = 0; halted_exp = 0;
      wait_prev = 0; prev_addr = '0; prev_xf = 0;
      rst = 1; redirect = 0; redirect_pc = '0; halt = 0;
      i_ready = 0; mem_ack = 0; mem_rdata = '0; ack_mode = 0;
      for (int i = 0; i < 65536; i++)
         mem[i] = ($urandom % 4 == 0) ? 8'hCB : 8'($urandom);
      mem[0] = 8'h3E; mem[1] = 8'h42; mem[2] = 8'hCB;
      mem[3] = 8'hCB; mem[4] = 8'h00; mem[5] = 8'h06;
      mem[6] = 8'hCB; mem[7] = 8'hCB;
      mem[16'h1234] = 8'h77; mem[16'hFFFF] = 8'h11;
      eb = '{8'h3E, 8'h42, 8'hCB, 8'hCB, 8'h00};
      ep = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

      @(negedge clk);
      cycle();
      cycle();
      rst = 0;
      settle();
      check("rst_instr", instr, 8'h00);
      check("rst_o_pc", o_pc, 16'h0000);
      check("rst_is16", o_is_instr16, 0);
      check("rst_o_valid", o_valid, 0);
      check("rst_fetch_rd", mem_rd, 1);
      check("rst_fetch_addr", mem_addr, 16'h0000);
      commit();

      i_ready = 1; ack_mode = 0;
      wait_log(5, 40);
      for (int i = 0; i < 5; i++) begin
         if (xlog.size() > i) begin
            check("seq_byte", xlog[i].b, eb[i]);
            check("seq_pc", xlog[i].pc, 32'(i));
            check("seq_is16", xlog[i].p, ep[i]);
         end
      end

      i_ready = 0; nw = 0;
      settle();
      while (!o_valid && nw < 20) begin
         commit();
         settle();
         nw++;
      end
      for (int k = 0; k < 5; k++) begin
         check("stall_instr", instr, 8'h06);
         check("stall_pc", o_pc, 16'h0005);
         check("stall_valid", o_valid, 1);
         commit();
         settle();
      end
      commit();

      i_ready = 1;
      wait_log(7, 40);
      ack_mode = 2;
      cycle();
      cycle();
      n0 = xlog.size();
      redirect = 1; redirect_pc = 16'h1234; ack_mode = 3;
      cycle();
      redirect = 0; ack_mode = 0;
      settle();
      check("redir_addr", mem_addr, 16'h1234);
      check("redir_rd", mem_rd, 1);
      commit();
      wait_log(n0 + 1, 20);
      if (xlog.size() > n0) begin
         check("redir_pc", xlog[n0].pc, 16'h1234);
         check("redir_byte", xlog[n0].b, 8'h77);
         check("redir_is16", xlog[n0].p, 0);
      end

      redirect = 1; redirect_pc = 16'hFFFF;
      cycle();
      redirect = 0;
      n0 = xlog.size();
      wait_log(n0 + 2, 30);
      if (xlog.size() > n0 + 1) begin
         check("wrap_pc0", xlog[n0].pc, 16'hFFFF);
         check("wrap_b0", xlog[n0].b, 8'h11);
         check("wrap_pc1", xlog[n0+1].pc, 16'h0000);
         check("wrap_b1", xlog[n0+1].b, 8'h3E);
      end

      halt = 1;
      n0 = xlog.size();
      wait_log(n0 + 1, 20);
      for (int k = 0; k < 4; k++) begin
         settle();
         check("halt_rd", mem_rd, 0);
         check("halt_valid", o_valid, 0);
         commit();
      end
      halt = 0;
      wait_log(n0 + 2, 20);

      b2b = 0;
      repeat (20) cycle();
`ifdef FETCH_PREFETCH_EN
      check("back_to_back", 32'(b2b > 0), 1);
`endif

      ack_mode = 1;
      for (int c = 0; c < 4000; c++) begin
         rst         = ($urandom % 400) == 0;
         redirect    = ($urandom % 30) == 0;
         redirect_pc = ($urandom % 4 == 0)
                     ? 16'hFFFF - 16'($urandom_range(0, 2))
                     : 16'($urandom);
         halt        = ($urandom % 8) == 0;
         i_ready     = ($urandom % 10) < 7;
         cycle();
      end
      rst = 0; redirect = 0; halt = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
